digit_mux_scheduler: RTL and testbench
======================================

Name: digit_mux_scheduler

Overview:
- Time-shares the single seven-segment decoder between two display digits.
- Sequences the two-bit digit-enable demux through a show/blank schedule and presents the matching nibble to the shared decoder.
- Double-buffers incoming digit values so both digits update together at a frame boundary, with no tearing.
- Sits between the keypad/data logic and the two_bit_demux + decoder pair.

Parameters:
- REFRESH_CYCLES, 24000, clk cycles each digit is shown per slot (>=1).
- BLANK_CYCLES, 4, clk cycles with both enables off between slots (>=0); removes ghosting.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-low reset
- load  input  1  one-cycle request to capture digit0/digit1
- digit0  input  4  new value for digit 0
- digit1  input  4  new value for digit 1
- load_ack  output  1  one-cycle pulse acknowledging a captured load
- seg_value  output  4  nibble driven to the shared seven-segment decoder
- digit_en  output  2  one-hot active-high enable to the demux; bit0 = digit 0, bit1 = digit 1
- frame_start  output  1  one-cycle pulse on the first SHOW0 cycle of each frame

Behaviour:
- Reset is synchronous and active-low, sampled at the clk rising edge. While reset=0:
  - state=SHOW0, slot counter=0
  - pending and active registers = 0
  - digit_en=2'b01, seg_value=4'h0, load_ack=0, frame_start=0
- Reset mid-operation aborts the current slot and discards any pending load.
- All outputs are registered and decoded from state (Moore style).
- FSM states: SHOW0 -> BLANK0 -> SHOW1 -> BLANK1 -> SHOW0.
  - SHOW states last exactly REFRESH_CYCLES cycles. The counter runs 0..REFRESH_CYCLES-1 and the state advances on the edge where count==REFRESH_CYCLES-1. The counter clears on every state change.
  - BLANK states last exactly BLANK_CYCLES cycles. If BLANK_CYCLES==0, the BLANK states are skipped (SHOW0 -> SHOW1 -> SHOW0).
  - Frame period = 2*(REFRESH_CYCLES+BLANK_CYCLES) cycles.
- digit_en by state:
  - SHOW0 = 01, SHOW1 = 10, BLANK0/BLANK1 = 00.
  - 11 never occurs.
- seg_value by state:
  - SHOW0 and BLANK1 present active0.
  - SHOW1 and BLANK0 present active1.
  - The next digit's value is therefore set up before its enable rises.
- Load handshake:
  - load=1 at an edge writes digit0/digit1 into the pending registers and sets pending_valid.
  - load_ack=1 for exactly one cycle after each sampled load. Back-to-back loads give back-to-back acks.
  - Multiple loads within one frame: last one wins.
- Frame-boundary transfer:
  - Occurs on the transition into SHOW0 from BLANK1 (from SHOW1 when BLANK_CYCLES==0).
  - If pending_valid=1, active <= pending and pending_valid is cleared. Otherwise active is unchanged.
  - If load=1 on that same edge, the incoming digit0/digit1 bypass into active directly, pending_valid ends 0, and load_ack still pulses.
- Displayed values never change mid-frame.
- frame_start is high during the first cycle of each SHOW0 entered from BLANK1/SHOW1. It is not asserted on the first SHOW0 after reset.
- Inputs are assumed synchronous to clk; no internal synchronizers.

Test Plan:
All scenarios use REFRESH_CYCLES=4, BLANK_CYCLES=2 (frame = 12 cycles) unless noted.

1. Reset schedule: hold reset=0 for 3 cycles -> digit_en=01, seg_value=0, load_ack=0. After release:
   - digit_en=01 for cycles 0-3
   - 00 for cycles 4-5
   - 10 for cycles 6-9
   - 00 for cycles 10-11
   - 01 again at cycle 12 with frame_start=1 for that one cycle only.
2. Load with deferred display: load=1 with digit0=4'h3, digit1=4'hA during SHOW1 (cycle 7) -> load_ack=1 at cycle 8 only. seg_value stays 0 through cycle 11. From cycle 12: seg_value=3 while digit_en=01 and 4'hA while digit_en=10.
3. Last load wins: loads of 5/6 at cycle 2 then 7/8 at cycle 8 -> two ack pulses. The next frame shows 7 on digit 0 and 8 on digit 1; 5/6 are never displayed.
4. Load on the boundary edge: load=1 with 4'hC/4'hD on the BLANK1->SHOW0 edge (cycle 11->12) -> seg_value=C in cycle 12, D in SHOW1 of the same frame, and load_ack=1 in cycle 12.
5. Reset mid-operation: load of 9/9 during SHOW0, then reset=0 for one cycle during SHOW1 -> outputs return to reset values. The pending 9/9 is never displayed; seg_value remains 0 for the following frames.
6. BLANK_CYCLES=0: digit_en alternates 01/10 every 4 cycles and is never 00. frame_start pulses every 8 cycles, and a load transfers at the SHOW1->SHOW0 edge.

Source files
------------

// File: rtl/digit_mux_scheduler.sv
// Two-digit display multiplexer for a shared seven-segment decoder.
// Walks SHOW0 -> BLANK0 -> SHOW1 -> BLANK1 and drives the demux enables.
// Incoming digit values are double-buffered and only take effect at a frame
// boundary, so both digits change together and never mid-frame.
module digit_mux_scheduler #(
  parameter int REFRESH_CYCLES = 24000,
  parameter int BLANK_CYCLES   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] digit0,
  input  logic [3:0] digit1,
  output logic       load_ack,
  output logic [3:0] seg_value,
  output logic [1:0] digit_en,
  output logic       frame_start
);

  localparam int CMAX = (REFRESH_CYCLES > BLANK_CYCLES) ? REFRESH_CYCLES : BLANK_CYCLES;
  localparam int CW   = (CMAX < 2) ? 1 : $clog2(CMAX);
  localparam logic [CW-1:0] R_LAST = CW'(REFRESH_CYCLES - 1);
  localparam logic [CW-1:0] B_LAST = (BLANK_CYCLES > 0) ? CW'(BLANK_CYCLES - 1) : '0;

  typedef enum logic [1:0] {SHOW0, BLANK0, SHOW1, BLANK1} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt;
  logic [3:0]    pend0, pend1, act0, act1;
  logic          pend_valid;
  logic          boundary;

  // Next-state: SHOW slots run REFRESH_CYCLES, BLANK slots BLANK_CYCLES;
  // a zero blank length bypasses the BLANK states entirely.
  always_comb begin
    state_n = state;
    unique case (state)
      SHOW0:  if (cnt == R_LAST) state_n = (BLANK_CYCLES == 0) ? SHOW1 : BLANK0;
      BLANK0: if (cnt == B_LAST) state_n = SHOW1;
      SHOW1:  if (cnt == R_LAST) state_n = (BLANK_CYCLES == 0) ? SHOW0 : BLANK1;
      BLANK1: if (cnt == B_LAST) state_n = SHOW0;
      default: state_n = SHOW0;
    endcase
    boundary = (state != SHOW0) && (state_n == SHOW0);
  end

  // Sequencer, slot counter, handshake pulses and the two-stage digit buffer.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= SHOW0;
      cnt         <= '0;
      pend0       <= 4'h0;
      pend1       <= 4'h0;
      act0        <= 4'h0;
      act1        <= 4'h0;
      pend_valid  <= 1'b0;
      load_ack    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= (state_n != state) ? '0 : cnt + CW'(1);
      load_ack    <= load;
      frame_start <= boundary;
      if (boundary) begin
        // A load on the boundary edge goes straight to the display.
        if (load) begin
          act0 <= digit0;
          act1 <= digit1;
        end else if (pend_valid) begin
          act0 <= pend0;
          act1 <= pend1;
        end
        pend_valid <= 1'b0;
      end else if (load) begin
        pend0      <= digit0;
        pend1      <= digit1;
        pend_valid <= 1'b1;
      end
    end
  end

  // Output decode from state; the next digit's nibble is set up during the
  // preceding blank so it is stable before its enable rises.
  always_comb begin
    digit_en  = 2'b00;
    seg_value = act1;
    unique case (state)
      SHOW0:  begin digit_en = 2'b01; seg_value = act0; end
      BLANK0: seg_value = act1;
      SHOW1:  begin digit_en = 2'b10; seg_value = act1; end
      BLANK1: seg_value = act0;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_digit_mux_scheduler.sv
// Randomised and directed bench for digit_mux_scheduler. Two instances share
// the inputs: A with a 2-cycle blank, B with blanking disabled. The reference
// model works from elapsed cycles since reset and frame arithmetic.
module tb_digit_mux_scheduler;
  localparam int R = 4;
  localparam int B [2] = '{2, 0};

  logic       clk = 0, reset = 0, load = 0;
  logic [3:0] digit0 = 0, digit1 = 0;
  logic       ack_a, fs_a, ack_b, fs_b;
  logic [3:0] seg_a, seg_b;
  logic [1:0] en_a, en_b;

  int errors = 0, checks = 0;

  // model state
  int         t = 0;
  logic [3:0] act0 [2], act1 [2], pnd0 [2], pnd1 [2];
  bit         pv [2], efs [2];
  bit         eack;

  always #5 clk = ~clk;

  digit_mux_scheduler #(.REFRESH_CYCLES(R), .BLANK_CYCLES(2)) dut_a (
    .clk(clk), .reset(reset), .load(load), .digit0(digit0), .digit1(digit1),
    .load_ack(ack_a), .seg_value(seg_a), .digit_en(en_a), .frame_start(fs_a));

  digit_mux_scheduler #(.REFRESH_CYCLES(R), .BLANK_CYCLES(0)) dut_b (
    .clk(clk), .reset(reset), .load(load), .digit0(digit0), .digit1(digit1),
    .load_ack(ack_b), .seg_value(seg_b), .digit_en(en_b), .frame_start(fs_b));

  function automatic logic [7:0] obs(int k);
    return (k == 0) ? {en_a, seg_a, ack_a, fs_a} : {en_b, seg_b, ack_b, fs_b};
  endfunction

  // Expected {digit_en, seg_value, load_ack, frame_start} for instance k now.
  function automatic logic [7:0] expv(int k);
    int ph = t % (2 * (R + B[k]));
    logic [1:0] en;
    logic [3:0] seg;
    if (ph < R)                 begin en = 2'b01; seg = act0[k]; end
    else if (ph < R + B[k])     begin en = 2'b00; seg = act1[k]; end
    else if (ph < 2 * R + B[k]) begin en = 2'b10; seg = act1[k]; end
    else                        begin en = 2'b00; seg = act0[k]; end
    return {en, seg, eack, efs[k]};
  endfunction

  // One clock: advance the model with the inputs sampled at this edge.
  task automatic tick();
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (!reset) begin
        act0[k] = 0; act1[k] = 0; pnd0[k] = 0; pnd1[k] = 0; pv[k] = 0; efs[k] = 0;
      end else begin
        efs[k] = ((t + 1) % (2 * (R + B[k])) == 0);
        if (efs[k]) begin
          if (load) begin act0[k] = digit0; act1[k] = digit1; end
          else if (pv[k]) begin act0[k] = pnd0[k]; act1[k] = pnd1[k]; end
          pv[k] = 0;
        end else if (load) begin
          pnd0[k] = digit0; pnd1[k] = digit1; pv[k] = 1;
        end
      end
    end
    if (!reset) begin t = 0; eack = 0; end
    else begin t++; eack = load; end
    #1;
  endtask

  task automatic test_reset();
    reset = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({en_a, seg_a, ack_a, fs_a} !== 8'b01_0000_0_0) begin
        errors++; $display("FAIL reset_vals got=%b want=%b", {en_a, seg_a, ack_a, fs_a}, 8'b01_0000_0_0);
      end
    end
    reset = 1;
  endtask

  task automatic test_schedule();
    // From cycle 0 through cycle 12 of the first frame after reset.
    logic [1:0] want_en;
    while (t < 12) begin
      tick();
      want_en = (t % 12 < 4) ? 2'b01 : (t % 12 < 6) ? 2'b00 : (t % 12 < 10) ? 2'b10 : 2'b00;
      checks++;
      if (en_a !== want_en || fs_a !== (t == 12)) begin
        errors++; $display("FAIL schedule t=%0d got en=%b fs=%b want en=%b fs=%b", t, en_a, fs_a, want_en, t == 12);
      end
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs(k) !== expv(k)) begin
          errors++; $display("FAIL schedule_model k=%0d t=%0d got=%b want=%b", k, t, obs(k), expv(k));
        end
      end
    end
  endtask

  task automatic do_reset();
    reset = 0; tick(); reset = 1;
  endtask

  task automatic run_until(int c, string name);
    while (t != c) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs(k) !== expv(k)) begin
          errors++; $display("FAIL %s k=%0d t=%0d got=%b want=%b", name, k, t, obs(k), expv(k));
        end
      end
    end
  endtask

  task automatic test_deferred_load();
    do_reset();
    run_until(7, "deferred");
    load = 1; digit0 = 4'h3; digit1 = 4'hA;
    tick(); load = 0;
    checks++;
    if (ack_a !== 1'b1) begin errors++; $display("FAIL deferred_ack got=%b want=1", ack_a); end
    run_until(9, "deferred");
    checks++;
    if (ack_a !== 1'b0 || seg_a !== 4'h0) begin
      errors++; $display("FAIL deferred_hold got ack=%b seg=%h want ack=0 seg=0", ack_a, seg_a);
    end
    run_until(12, "deferred");
    checks++;
    if (seg_a !== 4'h3 || en_a !== 2'b01) begin errors++; $display("FAIL deferred_d0 got=%h want=3", seg_a); end
    run_until(18, "deferred");
    checks++;
    if (seg_a !== 4'hA || en_a !== 2'b10) begin errors++; $display("FAIL deferred_d1 got=%h want=a", seg_a); end
  endtask

  task automatic test_last_wins();
    do_reset();
    run_until(2, "last_wins");
    load = 1; digit0 = 4'h5; digit1 = 4'h6; tick(); load = 0;
    run_until(8, "last_wins");
    load = 1; digit0 = 4'h7; digit1 = 4'h8; tick(); load = 0;
    checks++;
    if (ack_a !== 1'b1) begin errors++; $display("FAIL last_wins_ack got=%b want=1", ack_a); end
    run_until(13, "last_wins");
    checks++;
    if (seg_a !== 4'h7) begin errors++; $display("FAIL last_wins_d0 got=%h want=7", seg_a); end
    run_until(19, "last_wins");
    checks++;
    if (seg_a !== 4'h8) begin errors++; $display("FAIL last_wins_d1 got=%h want=8", seg_a); end
  endtask

  task automatic test_boundary_load();
    do_reset();
    run_until(11, "boundary");
    load = 1; digit0 = 4'hC; digit1 = 4'hD; tick(); load = 0;
    checks++;
    if (seg_a !== 4'hC || ack_a !== 1'b1 || fs_a !== 1'b1) begin
      errors++; $display("FAIL boundary_c got seg=%h ack=%b fs=%b want seg=c ack=1 fs=1", seg_a, ack_a, fs_a);
    end
    run_until(18, "boundary");
    checks++;
    if (seg_a !== 4'hD) begin errors++; $display("FAIL boundary_d got=%h want=d", seg_a); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    run_until(1, "reset_mid");
    load = 1; digit0 = 4'h9; digit1 = 4'h9; tick(); load = 0;
    run_until(7, "reset_mid");
    reset = 0; tick(); reset = 1;
    checks++;
    if ({en_a, seg_a, ack_a, fs_a} !== 8'b01_0000_0_0) begin
      errors++; $display("FAIL reset_mid_vals got=%b", {en_a, seg_a, ack_a, fs_a});
    end
    while (t < 30) begin
      tick();
      checks++;
      if (seg_a !== 4'h0 || seg_b !== 4'h0) begin
        errors++; $display("FAIL reset_mid_discard t=%0d got a=%h b=%h want 0", t, seg_a, seg_b);
      end
    end
  endtask

  task automatic test_no_blank();
    do_reset();
    run_until(3, "no_blank");
    load = 1; digit0 = 4'h4; digit1 = 4'hE; tick(); load = 0;
    while (t < 24) begin
      tick();
      checks++;
      if (en_b === 2'b00 || en_b !== ((t % 8 < 4) ? 2'b01 : 2'b10) || fs_b !== (t % 8 == 0)) begin
        errors++; $display("FAIL no_blank t=%0d got en=%b fs=%b", t, en_b, fs_b);
      end
      checks++;
      if (t >= 8 && seg_b !== ((t % 8 < 4) ? 4'h4 : 4'hE)) begin
        errors++; $display("FAIL no_blank_seg t=%0d got=%h", t, seg_b);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      reset  = ($urandom_range(0, 99) != 0);
      load   = ($urandom_range(0, 5) == 0);
      digit0 = 4'($urandom);
      digit1 = 4'($urandom);
      tick();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs(k) !== expv(k) || obs(k)[7:6] == 2'b11) begin
          errors++; $display("FAIL random k=%0d t=%0d got=%b want=%b", k, t, obs(k), expv(k));
        end
      end
    end
    reset = 1; load = 0;
  endtask

  initial begin
    test_reset();
    test_schedule();
    test_deferred_load();
    test_last_wins();
    test_boundary_load();
    test_reset_mid();
    test_no_blank();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
